// File: rtl/pipediv_stream_if.sv
// rtl/pipediv_stream_if.sv - operand/result stream bundle for the pipelined divider
interface pipediv_stream_if #(
    parameter int DIVIDEND = 8,
    parameter int DIVISOR  = 4,
    parameter int TAG_W    = 4
);
    logic                in_valid;
    logic                in_ready;
    logic                in_signed;
    logic [DIVIDEND-1:0] dividend;
    logic [DIVISOR-1:0]  divisor;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [DIVIDEND-1:0] quotient;
    logic [DIVISOR-1:0]  remainder;
    logic [TAG_W-1:0]    out_tag;
    logic                div_by_zero;
    logic                overflow;

    // Divider side: consumes operands, produces results.
    modport slave (
        input  in_valid, in_signed, dividend, divisor, in_tag, out_ready,
        output in_ready, out_valid, quotient, remainder, out_tag, div_by_zero, overflow
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_signed, dividend, divisor, in_tag, out_ready,
        input  in_ready, out_valid, quotient, remainder, out_tag, div_by_zero, overflow
    );
endinterface

// File: rtl/pipediv_stream.sv
// rtl/pipediv_stream.sv - fully pipelined signed/unsigned restoring divider with stream handshake
module pipediv_stream #(
    parameter int DIVIDEND  = 8,
    parameter int DIVISOR   = 4,
    parameter int TAG_W     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    pipediv_stream_if.slave       s
);
    localparam int N = DIVIDEND;
    localparam int M = DIVISOR;
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    // Pipeline stage registers: index 0 holds captured magnitudes, index i has resolved i quotient bits.
    logic [N:0]       st_v;
    logic [N:0]       st_negq;
    logic [N:0]       st_negr;
    logic [N:0]       st_dbz;
    logic [N:0]       st_ovf;
    logic [TAG_W-1:0] st_tag [0:N];
    logic [M-1:0]     st_raw [0:N];
    logic [M-1:0]     st_dvs [0:N];
    logic [M-1:0]     st_rem [0:N];
    logic [N-1:0]     st_dvd [0:N];

    logic [M-1:0]     nrem [1:N];
    logic [N-1:0]     ndvd [1:N];

    logic             r_valid;
    logic [N-1:0]     r_quot;
    logic [M-1:0]     r_rem;
    logic [TAG_W-1:0] r_tag;
    logic             r_dbz;
    logic             r_ovf;

    logic             stall;
    logic             en;
    logic             sm;
    logic             a_neg;
    logic             b_neg;
    logic [N-1:0]     a_mag;
    logic [M-1:0]     b_mag;
    logic             dbz_in;
    logic             ovf_in;

    logic [N-1:0]     fin_q;
    logic [M-1:0]     fin_r;
    logic             fin_dz;
    logic             fin_ov;

    // The whole pipe freezes while a result waits for the consumer; bubbles are not squeezed out.
    assign stall      = r_valid & ~s.out_ready;
    assign en         = ~stall;
    assign s.in_ready = ~stall;

    // Operand conditioning: signs, magnitudes and special-case detection for stage 0.
    always_comb begin
        sm     = (SIGNED_EN != 0) && s.in_signed;
        a_neg  = sm & s.dividend[N-1];
        b_neg  = sm & s.divisor[M-1];
        a_mag  = a_neg ? -s.dividend : s.dividend;
        b_mag  = b_neg ? -s.divisor  : s.divisor;
        dbz_in = (s.divisor == '0);
        ovf_in = sm && (s.dividend == MOST_NEG) && (s.divisor == '1);
    end

    // One restoring shift-subtract step per stage; partial remainder is one bit wider than the divisor.
    always_comb begin
        logic [M:0] sh;
        logic [M:0] df;
        logic       ge;
        for (int i = 1; i <= N; i++) begin
            sh      = {st_rem[i-1], st_dvd[i-1][N-1]};
            df      = sh - {1'b0, st_dvs[i-1]};
            ge      = (sh >= {1'b0, st_dvs[i-1]});
            nrem[i] = ge ? df[M-1:0] : sh[M-1:0];
            ndvd[i] = {st_dvd[i-1][N-2:0], ge};
        end
    end

    // Sign correction and special-case overrides applied to the last stage.
    always_comb begin
        fin_q  = st_negq[N] ? -st_dvd[N] : st_dvd[N];
        fin_r  = st_negr[N] ? -st_rem[N] : st_rem[N];
        fin_dz = st_dbz[N];
        fin_ov = st_ovf[N] & ~st_dbz[N];
        if (st_dbz[N]) begin
            fin_q = '1;
            fin_r = st_raw[N];
        end else if (st_ovf[N]) begin
            fin_q = MOST_NEG;
            fin_r = '0;
        end
    end

    // Advance every stage and the output register together unless stalled; reset drops all in-flight work.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_v    <= '0;
            st_negq <= '0;
            st_negr <= '0;
            st_dbz  <= '0;
            st_ovf  <= '0;
            for (int i = 0; i <= N; i++) begin
                st_tag[i] <= '0;
                st_raw[i] <= '0;
                st_dvs[i] <= '0;
                st_rem[i] <= '0;
                st_dvd[i] <= '0;
            end
            r_valid <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_tag   <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (en) begin
            st_v[0]    <= s.in_valid;
            st_negq[0] <= a_neg ^ b_neg;
            st_negr[0] <= a_neg;
            st_dbz[0]  <= dbz_in;
            st_ovf[0]  <= ovf_in;
            st_tag[0]  <= s.in_tag;
            st_raw[0]  <= s.dividend[M-1:0];
            st_dvs[0]  <= b_mag;
            st_rem[0]  <= '0;
            st_dvd[0]  <= a_mag;
            for (int i = 1; i <= N; i++) begin
                st_v[i]    <= st_v[i-1];
                st_negq[i] <= st_negq[i-1];
                st_negr[i] <= st_negr[i-1];
                st_dbz[i]  <= st_dbz[i-1];
                st_ovf[i]  <= st_ovf[i-1];
                st_tag[i]  <= st_tag[i-1];
                st_raw[i]  <= st_raw[i-1];
                st_dvs[i]  <= st_dvs[i-1];
                st_rem[i]  <= nrem[i];
                st_dvd[i]  <= ndvd[i];
            end
            r_valid <= st_v[N];
            r_quot  <= fin_q;
            r_rem   <= fin_r;
            r_tag   <= st_tag[N];
            r_dbz   <= st_v[N] & fin_dz;
            r_ovf   <= st_v[N] & fin_ov;
        end
    end

    assign s.out_valid   = r_valid;
    assign s.quotient    = r_quot;
    assign s.remainder   = r_rem;
    assign s.out_tag     = r_tag;
    assign s.div_by_zero = r_dbz;
    assign s.overflow    = r_ovf;
endmodule
